xoodyak_absorb_packer: RTL

XOODYAK_ABSORB_PACKER -- requirements
Module: xoodyak_absorb_packer

---
 rtl/xoodyak_pkg.sv | 22 ++
 rtl/xoodyak_mask_build.sv | 31 +++
 rtl/xoodyak_absorb_packer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/xoodyak_pkg.sv
// Shared constants and types for the Xoodyak hash absorb path.
//   STATE_W   : Xoodoo state width in bits
//   RATE_HASH : hash absorb rate in bytes
//   PAD_BYTE  : pad byte written right after the last data byte of a block
//   CD_FIRST / CD_NEXT : domain byte placed in the top state byte
//   state_e   : absorb packer FSM states
package xoodyak_pkg;

  localparam int unsigned STATE_W   = 384;
  localparam int unsigned RATE_HASH = 16;

  localparam logic [7:0] PAD_BYTE = 8'h01;
  localparam logic [7:0] CD_FIRST = 8'h03;
  localparam logic [7:0] CD_NEXT  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/xoodyak_mask_build.sv
// Combinational absorb-mask builder.
//   data   : collected block bytes, byte i in data[i]
//   n      : number of valid data bytes (0..RATE_BYTES)
//   first  : block is the first of its message
//   mask_c : STATE_W-bit XOR mask; data, then the pad byte at n, domain byte on top
module xoodyak_mask_build
  import xoodyak_pkg::*;
#(
  parameter int unsigned RATE_BYTES = RATE_HASH,
  parameter int unsigned IDX_W      = $clog2(RATE_BYTES + 1)
) (
  input  logic [RATE_BYTES-1:0][7:0] data,
  input  logic [IDX_W-1:0]           n,
  input  logic                       first,
  output logic [STATE_W-1:0]         mask_c
);

  // Rate bytes: data below n, pad exactly at n, zero above.
  for (genvar i = 0; i < int'(RATE_BYTES); i++) begin : g_rate
    assign mask_c[8*i +: 8] = (IDX_W'(i) < n)  ? data[i]  :
                              (IDX_W'(i) == n) ? PAD_BYTE : 8'h00;
  end

  // A full block pushes the pad just past the rate.
  assign mask_c[8*RATE_BYTES +: 8] = (n == IDX_W'(RATE_BYTES)) ? PAD_BYTE : 8'h00;

  assign mask_c[STATE_W-9 : 8*(RATE_BYTES+1)] = '0;

  assign mask_c[STATE_W-1 -: 8] = first ? CD_FIRST : CD_NEXT;

endmodule

// File: rtl/xoodyak_absorb_packer.sv
// Xoodyak hash absorb packer: collects message bytes into rate-sized blocks
// and presents each block as a padded XOR mask for the downstream core.
//   clk, resetn            : clock, asynchronous active-low reset
//   start, msg_len         : begin a message of msg_len bytes (ignored while busy)
//   msg, msg_valid/ready   : byte stream in
//   busy                   : message in progress
//   blk_mask/valid/last/ready : block out, held until accepted
//   err                    : only with XOODYAK_ABSORB_ERR_EN; sticky protocol error
//                            (start while busy, msg_valid in IDLE), cleared by an accepted start
module xoodyak_absorb_packer
  import xoodyak_pkg::*;
#(
  parameter int unsigned RATE_BYTES = RATE_HASH,
  parameter int unsigned LEN_W      = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic [7:0]         msg,
  input  logic               msg_valid,
  output logic               msg_ready,
  output logic               busy,
  output logic [STATE_W-1:0] blk_mask,
  output logic               blk_valid,
  output logic               blk_last,
  input  logic               blk_ready
`ifdef XOODYAK_ABSORB_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned IDX_W = $clog2(RATE_BYTES + 1);
  localparam int unsigned BI_W  = $clog2(RATE_BYTES);

  state_e                     state, state_n;
  logic [RATE_BYTES-1:0][7:0] data, data_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic [LEN_W-1:0]           rem, rem_n;
  logic                       first, first_n;
  logic                       msg_ready_n, busy_n, blk_valid_n, blk_last_n;
  logic [STATE_W-1:0]         blk_mask_n, mask_c;
`ifdef XOODYAK_ABSORB_ERR_EN
  logic                       err_n;
`endif

  // Mask is built from next-state values so blk_mask can be registered.
  xoodyak_mask_build #(
    .RATE_BYTES (RATE_BYTES),
    .IDX_W      (IDX_W)
  ) u_mask (
    .data   (data_n),
    .n      (idx_n),
    .first  (first_n),
    .mask_c (mask_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      data      <= '0;
      idx       <= '0;
      rem       <= '0;
      first     <= 1'b0;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_mask  <= '0;
    end else begin
      state     <= state_n;
      data      <= data_n;
      idx       <= idx_n;
      rem       <= rem_n;
      first     <= first_n;
      msg_ready <= msg_ready_n;
      busy      <= busy_n;
      blk_valid <= blk_valid_n;
      blk_last  <= blk_last_n;
      blk_mask  <= blk_mask_n;
    end
  end

`ifdef XOODYAK_ABSORB_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err <= 1'b0;
    else         err <= err_n;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    data_n  = data;
    idx_n   = idx;
    rem_n   = rem;
    first_n = first;
`ifdef XOODYAK_ABSORB_ERR_EN
    err_n   = err;
`endif

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          rem_n   = msg_len;
          idx_n   = '0;
          data_n  = '0;
          first_n = 1'b1;
          state_n = (msg_len != '0) ? ST_FILL : ST_EMIT;
        end
      end
      ST_FILL: begin
        if (msg_valid && msg_ready) begin
          data_n[idx[BI_W-1:0]] = msg;
          idx_n = idx + IDX_W'(1);
          rem_n = rem - LEN_W'(1);
          if (idx_n == IDX_W'(RATE_BYTES) || rem_n == '0) state_n = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          if (rem != '0) begin
            state_n = ST_FILL;
            first_n = 1'b0;
            idx_n   = '0;
            data_n  = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef XOODYAK_ABSORB_ERR_EN
    if (state == ST_IDLE) begin
      if (start)          err_n = 1'b0;
      else if (msg_valid) err_n = 1'b1;
    end else if (start) begin
      err_n = 1'b1;
    end
`endif

    msg_ready_n = (state_n == ST_FILL);
    busy_n      = (state_n != ST_IDLE);
    blk_valid_n = (state_n == ST_EMIT);
    blk_last_n  = (state_n == ST_EMIT) && (rem_n == '0);
    blk_mask_n  = (state_n == ST_EMIT) ? mask_c : '0;
  end

endmodule
